serial_tx: RTL
==============

Name: serial_tx

Overview:
Parallel-to-serial frame transmitter. Accepts a WIDTH-bit word through a ready/load handshake and shifts it out on a single serial line, LSB first, framed by one start bit (0) and one stop bit (1). Each bit is held for CLKS_PER_BIT clock cycles. It is the driving end of the serial link whose receive side samples the line through the team's D flip-flop capture stage.

Parameters:
WIDTH, 8, data bits per frame (>=1)
CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
data_in  input  WIDTH  word to transmit, sampled only on an accepted load
load  input  1  request to send data_in
ready  output  1  high when idle and able to accept load
busy  output  1  high while a frame is in progress (start through stop)
tx  output  1  serial line, idles high
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset: rst=1 at a rising edge forces the following on the next cycle, from any state, including mid-frame:
  - state IDLE, tx=1, ready=1, busy=0, done=0
  - bit and cycle counters cleared, shift register cleared
  - A partially sent frame is abandoned. No done pulse is issued for it.
- All outputs are registered. There is no combinational path from load or data_in to any output.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, ready=1, busy=0.
  - load=1 at an edge accepts the word: data_in is latched into the shift register and the FSM moves to START.
  - load=0 stays in IDLE.
- Timing, taking acceptance edge as E0 and C=CLKS_PER_BIT:
  - After E0: tx=0 (start bit), ready=0, busy=1, held for C cycles.
  - After edge E0+(1+i)*C, for i=0..WIDTH-1: tx=data bit i (LSB first), held C cycles, state DATA.
  - After edge E0+(WIDTH+1)*C: tx=1 (stop bit), held C cycles, state STOP.
  - After edge E0+(WIDTH+2)*C: state IDLE, tx=1, ready=1, busy=0, done=1 for exactly this one cycle.
  - Frame length: (WIDTH+2)*C cycles.
- load asserted while ready=0 is ignored. It is neither queued nor remembered.
- data_in changes after acceptance do not affect the frame in flight.
- Back-to-back frames:
  - load=1 during the done cycle is accepted at the next edge, because ready=1 in that cycle.
  - The minimum line gap between the stop bit and the next start bit is therefore one idle-high cycle.
- The cycle counter counts 0..C-1 and wraps. With C=1, every bit lasts exactly one cycle and the counter is constant 0. This case must work.
- The bit counter counts 0..WIDTH-1 and must be sized to hold WIDTH-1 (at least 1 bit wide).
- rst and load both high at the same edge: rst wins and load is ignored.

Test Plan:
- Reset: hold rst=1 for 2 cycles with load=1 -> tx=1, ready=1, busy=0, done=0 throughout. No frame starts.
- Single frame, WIDTH=8, C=4, data_in=8'hA5, load pulsed one cycle:
  - tx sequence in 4-cycle groups: 0, 1,0,1,0,0,1,0,1, 1.
  - done=1 exactly 40 cycles after the acceptance edge, for 1 cycle.
  - busy=1 for exactly 40 cycles.
- Load while busy: accept 8'h3C, then pulse load with data_in=8'hFF at cycles 5 and 20 -> frame on tx still encodes 8'h3C. No second frame follows.
- Reset mid-frame: accept 8'h00, assert rst for 1 cycle at cycle 15 -> tx=1 and ready=1 the next cycle, no done pulse. A new load of 8'h81 then sends a complete, correct frame.
- Back-to-back: hold load=1 continuously with data 8'h0F then 8'hF0 -> two correct frames, separated by exactly one tx=1 idle cycle after the first stop bit, with two done pulses.
- Edge parameters: WIDTH=1, C=1, data_in=1 -> tx=0,1,1 on consecutive cycles, done on cycle 3 after acceptance.

Source files
------------

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start(0), WIDTH data bits LSB first, stop(1), each held CLKS_PER_BIT cycles.
// Registered outputs; ready is high only in IDLE (including the done cycle), so loads during a frame are dropped.
module serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             busy,
  output logic             tx,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    clk_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;

  wire bit_end = (clk_cnt == LAST_CLK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state   <= START;
            shreg   <= data_in;
            clk_cnt <= '0;
            bit_cnt <= '0;
            tx      <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= DATA;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            // Frame ends here; ready rises with done so a back-to-back load is taken next edge.
            clk_cnt <= '0;
            state   <= IDLE;
            tx      <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
